gates: RTL and testbench

//   Registered two-input logic unit: computes bitwise AND, OR and XOR of operands a and b.

---
 rtl/gates_pkg.sv | 30 +++
 rtl/gates_bit.sv | 31 +++
 rtl/gates.sv | 87 ++++++++
 tb/tb_gates.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/gates_pkg.sv
// Shared definitions for the gates block.
//   GATES_WIDTH_DEFAULT : default operand/result width
//   gate_op_e           : selects one of the three basic gate functions
//   ref_gate()          : golden bitwise model used by the bench scoreboard
package gates_pkg;

  localparam int unsigned GATES_WIDTH_DEFAULT = 1;
  localparam int unsigned GATES_REF_WIDTH     = 64;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2
  } gate_op_e;

  // Golden model: bitwise gate on up to GATES_REF_WIDTH bits.
  function automatic logic [GATES_REF_WIDTH-1:0] ref_gate(
    input gate_op_e                   op,
    input logic [GATES_REF_WIDTH-1:0] a,
    input logic [GATES_REF_WIDTH-1:0] b
  );
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/gates_bit.sv
// One-bit combinational gate slice built from gate primitives.
// Optional macro GATES_INV_OUT_EN adds the complemented (nand/nor/xnor) outputs.
// Ports:
//   a, b                    one bit of each operand
//   y_and, y_or, y_xor      a&b, a|b, a^b
//   y_nand, y_nor, y_xnor   ~(a&b), ~(a|b), ~(a^b)   (GATES_INV_OUT_EN only)
module gates_bit (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_or,
  output logic y_xor
`ifdef GATES_INV_OUT_EN
  ,
  output logic y_nand,
  output logic y_nor,
  output logic y_xnor
`endif
);

  and  u_and  (y_and, a, b);
  or   u_or   (y_or,  a, b);
  xor  u_xor  (y_xor, a, b);

`ifdef GATES_INV_OUT_EN
  nand u_nand (y_nand, a, b);
  nor  u_nor  (y_nor,  a, b);
  xnor u_xnor (y_xnor, a, b);
`endif

endmodule

// File: rtl/gates.sv
// Registered two-input logic unit: bitwise AND/OR/XOR of a and b, one cycle latency.
// Optional macro GATES_INV_OUT_EN adds registered complements cn/dn/en_o.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over in_valid)
//   in_valid   capture enable for a/b
//   a, b       WIDTH-bit operands
//   c, d, e    registered a&b, a|b, a^b (hold when in_valid=0)
//   out_valid  c/d/e were captured from a valid input on the last edge
//   cn, dn, en_o  registered ~(a&b), ~(a|b), ~(a^b)   (GATES_INV_OUT_EN only)
module gates
  import gates_pkg::*;
#(
  parameter int unsigned WIDTH = GATES_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic             out_valid
`ifdef GATES_INV_OUT_EN
  ,
  output logic [WIDTH-1:0] cn,
  output logic [WIDTH-1:0] dn,
  output logic [WIDTH-1:0] en_o
`endif
);

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] xor_w;
`ifdef GATES_INV_OUT_EN
  logic [WIDTH-1:0] nand_w;
  logic [WIDTH-1:0] nor_w;
  logic [WIDTH-1:0] xnor_w;
`endif

  // One independent slice per bit: no carries between bits.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    gates_bit u_bit (
      .a     (a[i]),
      .b     (b[i]),
      .y_and (and_w[i]),
      .y_or  (or_w[i]),
      .y_xor (xor_w[i])
`ifdef GATES_INV_OUT_EN
      ,
      .y_nand(nand_w[i]),
      .y_nor (nor_w[i]),
      .y_xnor(xnor_w[i])
`endif
    );
  end

  // Result registers: clear on reset, load on valid, otherwise hold.
  // Complements are separate flops so they read 0 in reset rather than all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      d         <= '0;
      e         <= '0;
      out_valid <= 1'b0;
`ifdef GATES_INV_OUT_EN
      cn        <= '0;
      dn        <= '0;
      en_o      <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        c    <= and_w;
        d    <= or_w;
        e    <= xor_w;
`ifdef GATES_INV_OUT_EN
        cn   <= nand_w;
        dn   <= nor_w;
        en_o <= xnor_w;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gates.sv
// Self-checking bench for gates: a WIDTH=8 and a WIDTH=1 instance share clk/rst/in_valid.
// Expected outputs are computed by a scoreboard model when stimulus is driven and
// compared one edge later; fixed-value checks cover the directed cases.
module tb_gates;
  import gates_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a8, b8, c8, d8, e8;
  logic       a1, b1, c1, d1, e1;
  logic       ov8, ov1;
`ifdef GATES_INV_OUT_EN
  logic [7:0] cn8, dn8, en8;
  logic       cn1, dn1, en1;
`endif

  always #5 clk = ~clk;

  gates #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .c(c8), .d(d8), .e(e8), .out_valid(ov8)
`ifdef GATES_INV_OUT_EN
    , .cn(cn8), .dn(dn8), .en_o(en8)
`endif
  );

  gates #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .c(c1), .d(d1), .e(e1), .out_valid(ov1)
`ifdef GATES_INV_OUT_EN
    , .cn(cn1), .dn(dn1), .en_o(en1)
`endif
  );

  typedef struct packed {
    logic       v;
    logic [7:0] c, d, e, cn, dn, en;
    logic       c1, d1, e1, cn1, dn1, en1;
  } exp_t;

  exp_t sb[$];
  exp_t model = '0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic step(input logic r, input logic iv, input logic [7:0] ai, input logic [7:0] bi,
                      input logic a1i, input logic b1i);
    exp_t x;
    rst = r; in_valid = iv; a8 = ai; b8 = bi; a1 = a1i; b1 = b1i;
    if (r) begin
      model = '0;
    end else if (iv) begin
      model.v   = 1'b1;
      model.c   = 8'(ref_gate(OP_AND, 64'(ai), 64'(bi)));
      model.d   = 8'(ref_gate(OP_OR,  64'(ai), 64'(bi)));
      model.e   = 8'(ref_gate(OP_XOR, 64'(ai), 64'(bi)));
      model.cn  = ~model.c;
      model.dn  = ~model.d;
      model.en  = ~model.e;
      model.c1  = 1'(ref_gate(OP_AND, 64'(a1i), 64'(b1i)));
      model.d1  = 1'(ref_gate(OP_OR,  64'(a1i), 64'(b1i)));
      model.e1  = 1'(ref_gate(OP_XOR, 64'(a1i), 64'(b1i)));
      model.cn1 = ~model.c1;
      model.dn1 = ~model.d1;
      model.en1 = ~model.e1;
    end else begin
      model.v = 1'b0;
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 64'(sb.size()), 64'd1);
    end else begin
      x = sb.pop_front();
      check_eq("ov8", 64'(ov8), 64'(x.v));
      check_eq("c8",  64'(c8),  64'(x.c));
      check_eq("d8",  64'(d8),  64'(x.d));
      check_eq("e8",  64'(e8),  64'(x.e));
      check_eq("ov1", 64'(ov1), 64'(x.v));
      check_eq("c1",  64'(c1),  64'(x.c1));
      check_eq("d1",  64'(d1),  64'(x.d1));
      check_eq("e1",  64'(e1),  64'(x.e1));
`ifdef GATES_INV_OUT_EN
      check_eq("cn8", 64'(cn8), 64'(x.cn));
      check_eq("dn8", 64'(dn8), 64'(x.dn));
      check_eq("en8", 64'(en8), 64'(x.en));
      check_eq("cn1", 64'(cn1), 64'(x.cn1));
      check_eq("dn1", 64'(dn1), 64'(x.dn1));
      check_eq("en1", 64'(en1), 64'(x.en1));
`endif
    end
  endtask

  initial begin
    logic [2:0] sweep_exp [4];
    logic [1:0] ab;
    sweep_exp[0] = 3'b000;
    sweep_exp[1] = 3'b011;
    sweep_exp[2] = 3'b011;
    sweep_exp[3] = 3'b110;

    // Reset held two cycles with valid operands present.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
      check_eq("rst_ov", 64'({ov8, ov1}), 64'd0);
      check_eq("rst_cde", 64'({c8, d8, e8, c1, d1, e1}), 64'd0);
`ifdef GATES_INV_OUT_EN
      check_eq("rst_inv", 64'({cn8, dn8, en8, cn1, dn1, en1}), 64'd0);
`endif
    end

    // Truth-table sweep on the scalar instance.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step(1'b0, 1'b1, 8'(i), 8'(i), ab[1], ab[0]);
      check_eq("sweep_cde", 64'({c1, d1, e1}), 64'(sweep_exp[i]));
      check_eq("sweep_ov", 64'(ov1), 64'd1);
    end

    // Random back-to-back valid inputs.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    // Capture then hold with invalid (changing) operands.
    step(1'b0, 1'b1, 8'hA5, 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1);
      check_eq("hold_cde1", 64'({c1, d1, e1}), 64'b011);
      check_eq("hold_c8", 64'(c8), 64'h05);
      check_eq("hold_ov", 64'({ov8, ov1}), 64'd0);
    end

    // Width-8 directed pattern.
    step(1'b0, 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0);
    check_eq("w8_c", 64'(c8), 64'h30);
    check_eq("w8_d", 64'(d8), 64'hFC);
    check_eq("w8_e", 64'(e8), 64'hCC);
`ifdef GATES_INV_OUT_EN
    check_eq("w8_cn", 64'(cn8), 64'hCF);
    check_eq("w8_dn", 64'(dn8), 64'h03);
    check_eq("w8_en", 64'(en8), 64'h33);
`endif

    // Mid-stream reset pulse, then normal capture resumes.
    step(1'b0, 1'b1, 8'h5A, 8'hC3, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0);
    check_eq("midrst_c8", 64'({c8, d8, e8}), 64'd0);
    check_eq("midrst_ov", 64'({ov8, ov1}), 64'd0);
    step(1'b0, 1'b1, 8'h81, 8'h18, 1'b0, 1'b1);
    check_eq("post_rst_d8", 64'(d8), 64'h99);
    check_eq("post_rst_ov", 64'({ov8, ov1}), 64'b11);

    for (int i = 0; i < 5; i++)
      step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
